// File: rtl/md5_match_checker.sv
// md5_match_checker
// Consumes the md5core result stream. Each accepted hash is compared against a
// host-loaded 128-bit target. The first hit latches the candidate message and
// its stream index, which are then held on a valid/ack handshake. A saturating
// count of checked hashes lets the host track progress, and a sticky flag
// records any match that arrived while another one was still pending.
//
// Ports
//   clk          in   system clock
//   reset_n      in   synchronous active-low reset
//   en           in   global enable; low freezes everything
//   start        in   pulse: latch target, clear results, enter SEARCH
//   stop         in   pulse: return to IDLE (results retained)
//   target       in   128-bit target hash {A,B,C,D}
//   a_in..d_in   in   hash words from md5core
//   m_in         in   512-bit padded message block from md5core
//   valid_in     in   hash/message inputs valid
//   match_ack    in   host consumed the pending match
//   match_valid  out  match pending
//   match_msg    out  captured candidate message (MSBs of m_in)
//   match_index  out  0-based stream index of the captured match
//   hash_count   out  hashes checked since start (saturating)
//   match_lost   out  sticky: a match was dropped while one was pending
//   busy         out  high in SEARCH or HOLD
//
// state  | meaning
// IDLE   | no search running; results ignored
// SEARCH | counting results, waiting for a hit
// HOLD   | hit captured, waiting for match_ack; further hits are lost

module md5_match_checker #(
  parameter int MSG_BITS = 152,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                start,
  input  logic                stop,
  input  logic [127:0]        target,
  input  logic [31:0]         a_in,
  input  logic [31:0]         b_in,
  input  logic [31:0]         c_in,
  input  logic [31:0]         d_in,
  input  logic [511:0]        m_in,
  input  logic                valid_in,
  input  logic                match_ack,
  output logic                match_valid,
  output logic [MSG_BITS-1:0] match_msg,
  output logic [CNT_W-1:0]    match_index,
  output logic [CNT_W-1:0]    hash_count,
  output logic                match_lost,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [127:0]        target_q, target_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [MSG_BITS-1:0] msg_q, msg_d;
  logic                valid_q, valid_d;
  logic                lost_q, lost_d;
  logic                busy_q, busy_d;

  logic                hit;
  logic                accept;
  logic [CNT_W-1:0]    cnt_inc;

  // Only the candidate-message bits of the block are of interest.
  logic                unused_m;
  assign unused_m = ^m_in[511-MSG_BITS:0];

  assign hit = (a_in == target_q[127:96]) && (b_in == target_q[95:64]) &&
               (c_in == target_q[63:32])  && (d_in == target_q[31:0]);

  assign accept = valid_in && (state_q != IDLE);

  // Saturate rather than wrap so the host never sees a falsely small count.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    msg_d    = msg_q;
    valid_d  = valid_q;
    lost_d   = lost_q;

    if (en) begin
      if (stop) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end else if (start) begin
        // A restart discards any pending match and the result of this cycle.
        state_d  = SEARCH;
        target_d = target;
        cnt_d    = '0;
        idx_d    = '0;
        msg_d    = '0;
        valid_d  = 1'b0;
        lost_d   = 1'b0;
      end else begin
        if (accept) begin
          cnt_d = cnt_inc;
        end
        case (state_q)
          SEARCH: begin
            if (accept && hit) begin
              msg_d   = m_in[511 -: MSG_BITS];
              idx_d   = cnt_q;
              valid_d = 1'b1;
              state_d = HOLD;
            end
          end
          HOLD: begin
            // A hit here is never captured, even when ack arrives with it.
            if (accept && hit) begin
              lost_d = 1'b1;
            end
            if (match_ack) begin
              valid_d = 1'b0;
              state_d = SEARCH;
            end
          end
          default: ;
        endcase
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      msg_q    <= '0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      msg_q    <= msg_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
      busy_q   <= busy_d;
    end
  end

  assign match_valid = valid_q;
  assign match_msg   = msg_q;
  assign match_index = idx_q;
  assign hash_count  = cnt_q;
  assign match_lost  = lost_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_md5_match_checker.sv
// Bench for md5_match_checker. Runs a table of single-cycle stimulus records
// against a 32-bit-counter instance, then a saturation sequence against a
// 4-bit-counter instance sharing the same inputs.

module tb_md5_match_checker;

  // Only equality against the target matters to the checker, so hash2/hash3
  // are simply distinct words.
  localparam logic [127:0] H1 = 128'ha2004f37_730b9445_670a738f_a0fc9ee5;
  localparam logic [127:0] H2 = 128'h1b2c3d4e_5f607182_93a4b5c6_d7e8f901;
  localparam logic [127:0] H3 = 128'hc0ffee11_22334455_66778899_aabbccdd;
  localparam logic [151:0] FOX_HEX = 152'h54686520_71756963_6b206272_6f776e20_666f78;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, en, start, stop, valid_in, match_ack;
  logic [127:0] target;
  logic [31:0]  a_in, b_in, c_in, d_in;
  logic [511:0] m_in;

  logic         mv0, ml0, bz0;
  logic [151:0] mm0;
  logic [31:0]  mi0, hc0;
  logic         mv1, ml1, bz1;
  logic [151:0] mm1;
  logic [3:0]   mi1, hc1;

  md5_match_checker #(.MSG_BITS(152), .CNT_W(32)) dut0 (
    .clk(clk), .reset_n(reset_n), .en(en), .start(start), .stop(stop),
    .target(target), .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .m_in(m_in), .valid_in(valid_in), .match_ack(match_ack),
    .match_valid(mv0), .match_msg(mm0), .match_index(mi0),
    .hash_count(hc0), .match_lost(ml0), .busy(bz0)
  );

  md5_match_checker #(.MSG_BITS(152), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .start(start), .stop(stop),
    .target(target), .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .m_in(m_in), .valid_in(valid_in), .match_ack(match_ack),
    .match_valid(mv1), .match_msg(mm1), .match_index(mi1),
    .hash_count(hc1), .match_lost(ml1), .busy(bz1)
  );

  typedef struct {
    bit rn, en, st, sp, ack, vin;
    int hs, ms, ts;
    bit ev;
    int ei, ec;
    bit el, eb;
    int em;
    int dut;
  } vec_t;

  typedef struct {
    bit           v;
    logic [31:0]  idx, cnt;
    bit           lost, busy;
    logic [151:0] msg;
    int           dut;
    int           id;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   step_id = 0;

  function automatic logic [127:0] hash_of(int s);
    case (s)
      1: return H1;
      2: return H2;
      3: return H3;
      default: return 128'h0;
    endcase
  endfunction

  function automatic logic [151:0] str_of(int s);
    logic [151:0] m;
    case (s)
      1: m = "Hello World 1234567";
      2: m = "The quick brown fox";
      3: m = "This is a test. 123";
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [151:0] emsg_of(int s);
    case (s)
      1: return 152'h48656c6c_6f20576f_726c6420_31323334_353637;
      2: return FOX_HEX;
      3: return 152'h54686973_20697320_61207465_73742e20_313233;
      default: return 152'h0;
    endcase
  endfunction

  function automatic vec_t mk(bit rn, bit e, bit st, bit sp, bit ack, bit vin,
                              int hs, int ms, int ts,
                              bit ev, int ei, int ec, bit el, bit eb, int em);
    vec_t x;
    x.rn = rn; x.en = e; x.st = st; x.sp = sp; x.ack = ack; x.vin = vin;
    x.hs = hs; x.ms = ms; x.ts = ts;
    x.ev = ev; x.ei = ei; x.ec = ec; x.el = el; x.eb = eb; x.em = em;
    x.dut = 0;
    return x;
  endfunction

  task automatic chk(string nm, int id, logic [151:0] act, logic [151:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
    end
  endtask

  task automatic step(vec_t x);
    exp_t e, g;
    reset_n   = x.rn;
    en        = x.en;
    start     = x.st;
    stop      = x.sp;
    match_ack = x.ack;
    valid_in  = x.vin;
    {a_in, b_in, c_in, d_in} = hash_of(x.hs);
    m_in      = {str_of(x.ms), 8'h80, 352'h0};
    target    = hash_of(x.ts);
    e.v = x.ev; e.idx = 32'(x.ei); e.cnt = 32'(x.ec);
    e.lost = x.el; e.busy = x.eb; e.msg = emsg_of(x.em);
    e.dut = x.dut; e.id = step_id;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    if (g.dut == 0) begin
      chk("match_valid", g.id, 152'(mv0), 152'(g.v));
      chk("match_index", g.id, 152'(mi0), 152'(g.idx));
      chk("hash_count",  g.id, 152'(hc0), 152'(g.cnt));
      chk("match_lost",  g.id, 152'(ml0), 152'(g.lost));
      chk("busy",        g.id, 152'(bz0), 152'(g.busy));
      chk("match_msg",   g.id, mm0, g.msg);
    end else begin
      chk("sat_match_valid", g.id, 152'(mv1), 152'(g.v));
      chk("sat_match_index", g.id, 152'(mi1), 152'(g.idx));
      chk("sat_hash_count",  g.id, 152'(hc1), 152'(g.cnt));
      chk("sat_match_lost",  g.id, 152'(ml1), 152'(g.lost));
      chk("sat_match_msg",   g.id, mm1, g.msg);
    end
    step_id++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    reset_n = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0;
    valid_in = 1'b0; match_ack = 1'b0; target = '0;
    a_in = '0; b_in = '0; c_in = '0; d_in = '0; m_in = '0;
    @(posedge clk);
    #1;

    //            rn en st sp ak vi hs ms ts | ev ei ec el eb em
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)); // reset
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0)); // start H1
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 2, 1, 0,  0, 0, 1, 0, 1, 0)); // hash2
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 2, 0,  1, 1, 2, 0, 1, 2)); // hash1 hit
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 3, 3, 0,  1, 1, 3, 0, 1, 2)); // hash3
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 2, 1, 0,  0, 1, 4, 0, 1, 2)); // ack + 4th
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 2, 0,  1, 4, 5, 0, 1, 2)); // 5th hits
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0,  0, 4, 5, 0, 1, 2)); // ack
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 3,  0, 4, 5, 0, 0, 2)); // start+stop
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 1, 0,  0, 4, 5, 0, 0, 2)); // idle ignores
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 1, 0)); // start H3
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 3, 3, 0,  1, 0, 1, 0, 1, 3)); // hit
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 3, 1, 0,  1, 0, 2, 1, 1, 3)); // lost
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 3, 2, 0,  0, 0, 3, 1, 1, 3)); // ack+hit
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 3, 1, 0,  1, 3, 4, 1, 1, 1)); // in SEARCH
    tbl.push_back(mk(1, 0, 1, 0, 1, 1, 3, 2, 1,  1, 3, 4, 1, 1, 1)); // en low
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0,  1, 3, 4, 1, 1, 1)); // en low stop
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0,  0, 3, 4, 1, 0, 1)); // stop
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0)); // start H1
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 2, 0,  1, 0, 1, 0, 1, 2)); // hit
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 2, 0,  0, 0, 0, 0, 0, 0)); // reset in HOLD
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 1, 2, 1,  0, 0, 0, 0, 0, 0)); // en low start
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0)); // start H1

    foreach (tbl[i]) step(tbl[i]);

    // Saturation on the 4-bit counter instance.
    v = mk(1, 1, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0);
    v.dut = 1;
    step(v);
    for (int i = 0; i < 20; i++) begin
      v = mk(1, 1, 0, 0, 0, 1, 2, 1, 0,  0, 0, (i + 1 > 15) ? 15 : i + 1, 0, 1, 0);
      v.dut = 1;
      step(v);
    end
    v = mk(1, 1, 0, 0, 0, 1, 1, 2, 0,  1, 15, 15, 0, 1, 2);
    v.dut = 1;
    step(v);
    v = mk(1, 1, 0, 0, 0, 1, 1, 3, 0,  1, 15, 15, 1, 1, 2);
    v.dut = 1;
    step(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md5_match_checker.md
# md5_match_checker

Result-side consumer of the `md5core` output stream. It compares each hash produced by the pipeline against a host-loaded 128-bit target hash. On the first hit it latches the 19-byte candidate message and its stream index, then holds them on a valid/ack handshake until the host (UART/command layer) collects them. It also keeps a count of hashes checked, so the host can track search progress and detect lost matches.

## Interface
Parameters:
- `MSG_BITS`, 152: candidate message width, taken from the MSBs of the 512-bit block.
- `CNT_W`, 32: width of the hash counter and the match index.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, synchronous and active-low.
- `en`  in  1  global enable; when low, all state holds.
- `start`  in  1  one-cycle pulse that latches `target` and begins or restarts a search.
- `stop`  in  1  one-cycle pulse that aborts and returns to IDLE.
- `target`  in  128  target hash {A,B,C,D}; sampled only on `start`.
- `a_in`, `b_in`, `c_in`, `d_in`  in  32 each  hash words from `md5core`.
- `m_in`  in  512  padded message block from `md5core` (`m_out`).
- `valid_in`  in  1  the hash and message inputs are valid this cycle.
- `match_ack`  in  1  host has consumed the pending match.
- `match_valid`  out  1  a match is pending.
- `match_msg`  out  `MSG_BITS`  captured `m_in[511:512-MSG_BITS]`.
- `match_index`  out  `CNT_W`  0-based stream index of the matching hash.
- `hash_count`  out  `CNT_W`  number of hashes checked since `start`.
- `match_lost`  out  1  sticky flag: a match arrived while another was pending.
- `busy`  out  1  high in SEARCH or HOLD.

## Operation
- FSM states are IDLE, SEARCH and HOLD.
- A hash matches when `a_in==target_q[127:96]`, `b_in==target_q[95:64]`, `c_in==target_q[63:32]` and `d_in==target_q[31:0]`. This is the same word order that `md5core` emits.
- A result is "accepted" when `en && valid_in` and the state is SEARCH or HOLD.
- IDLE:
  - `start` latches `target_q`.
  - It clears `hash_count`, `match_lost`, `match_msg`, `match_index` and `match_valid`.
  - The FSM then moves to SEARCH.
- SEARCH:
  - Every accepted result increments `hash_count`.
  - An accepted result that matches captures `match_msg` and `match_index` (the pre-increment `hash_count`), sets `match_valid` and moves to HOLD.
- HOLD:
  - Accepted results still increment `hash_count`.
  - An accepted result that matches sets `match_lost`. That match is dropped, and the captured data does not change.
  - `match_ack` clears `match_valid` and returns to SEARCH. The captured data is retained until the next capture or `start`.
- `stop` in any state moves to IDLE and clears `match_valid`. `hash_count`, `match_lost` and the captured data are retained for readback.
- `start` in SEARCH or HOLD restarts exactly as it does from IDLE. Any pending match is discarded.
- `hash_count` saturates at all-ones and does not wrap. Once saturated, `match_index` reports all-ones.
- `en` low freezes the FSM and all registers. Inputs are ignored in that cycle, including `start`, `stop` and `match_ack`.

## Timing
- Reset:
  - It is synchronous: the state is IDLE after the first `posedge clk` with `reset_n` low.
  - All outputs are 0 in reset: `match_valid`, `match_msg`, `match_index`, `hash_count`, `match_lost`, `busy`.
  - Reset mid-operation aborts immediately, and a pending match is lost.
- Latency:
  - `match_valid`, `match_msg` and `match_index` are registered. They are visible one cycle after the edge that samples the matching `valid_in`.
  - `hash_count` updates on the same edge.
- `valid_in` may be high on consecutive cycles, since `md5core` emits one result per cycle. No result is skipped in counting.
- Precedence on the same cycle is `reset_n` > `stop` > `start` > `match_ack` > data capture.
- `match_ack` and a new match on the same cycle in HOLD:
  - The ack wins and the FSM returns to SEARCH.
  - The new match sets `match_lost` and is not captured.
- `match_ack` outside HOLD is ignored.
- `busy` is a registered function of the state.

## Test plan
- Basic match: `start` with target `a2004f37_730b9445_670a738f_a0fc9ee5`, then three results of {hash2, hash1, hash3}. The MSBs of `m_in` carry "Hello World 1234567" (`48656c6c…353637`), "The quick brown fox" (`54686520…666f78`) and "This is a test. 123" (`54686973…313233`) respectively. Required: `match_valid`=1 one cycle after the second result; `match_msg`=`54686520_71756963_6b206272_6f776e20_666f78`; `match_index`=1; final `hash_count`=3.
- Back-to-back matches: the target is hash3 and two consecutive hash3 results arrive without ack. Required: capture from the first; `match_index`=0; `match_lost`=1; `hash_count`=2.
- Ack/resume: after the basic match, pulse `match_ack`, then feed hash1 again as the 5th result. Required: `match_valid` drops for exactly one cycle, then re-asserts with `match_index`=4.
- Simultaneous events: assert `start` and `stop` on the same cycle from SEARCH. Required: IDLE, `busy`=0, target not re-latched. Then assert `match_ack` together with a matching result in HOLD. Required: SEARCH, `match_valid`=0, `match_lost`=1.
- Saturation: use `CNT_W`=4 and feed 20 non-matching results. Required: `hash_count` holds at 15. A later match reports `match_index`=15.
- Reset/enable: drop `reset_n` while in HOLD. Required: all outputs are 0 on the next cycle. With `en`=0, a matching result and `start` have no effect.
